// File: rtl/vram_filler.sv
// VRAM pattern filler: writes CONST/INCR/LFSR/CHECKER data over a word region, one strobe every div+1 clocks.
// First strobe one cycle after an accepted start; no backpressure, abort or reset ends a fill without done.
module vram_filler #(
   parameter int                ADDR_W    = 10,
   parameter int                DATA_W    = 16,
   parameter int                DIV_W     = 17,
   parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(16'hB400),
   parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(16'h0001)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [1:0]        mode_i,
   input  logic              loop_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] len_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic [DATA_W-1:0] const_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              vram_ce_o,
   output logic [ADDR_W-1:0] vram_ad_o,
   output logic [DATA_W-1:0] vram_din_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_CONST = 2'd0;
   localparam logic [1:0] MODE_INCR  = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;

   state_t              state;
   logic [1:0]          mode_r;
   logic                loop_r;
   logic [ADDR_W-1:0]   base_r;
   logic [ADDR_W-1:0]   len_r;
   logic [DIV_W-1:0]    div_r;
   logic [DATA_W-1:0]   const_r;
   logic [ADDR_W-1:0]   offset;
   logic [DIV_W-1:0]    wait_cnt;
   logic [DATA_W-1:0]   lfsr;

   logic                last_word;
   logic [ADDR_W-1:0]   offset_nx;
   logic [DATA_W-1:0]   lfsr_nx;

   function automatic logic [DATA_W-1:0] fill_data(
      input logic [1:0]        m,
      input logic [DATA_W-1:0] c,
      input logic [ADDR_W-1:0] off,
      input logic [DATA_W-1:0] lf
   );
      logic [DATA_W-1:0] d;
      case (m)
         MODE_CONST: d = c;
         MODE_INCR:  d = DATA_W'(off);
         MODE_LFSR:  d = lf;
         default:    d = off[0] ? ~c : c;
      endcase
      return d;
   endfunction

   // Outputs are registered, so the next write's address/data are computed one
   // cycle ahead from the post-advance offset and LFSR values.
   always_comb begin
      last_word = (offset == len_r);
      offset_nx = last_word ? '0 : offset + ADDR_W'(1);
      if (lfsr == '0)
         lfsr_nx = LFSR_SEED;
      else
         lfsr_nx = {lfsr[DATA_W-2:0], ^(lfsr & LFSR_TAPS)};
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         mode_r     <= '0;
         loop_r     <= 1'b0;
         base_r     <= '0;
         len_r      <= '0;
         div_r      <= '0;
         const_r    <= '0;
         offset     <= '0;
         wait_cnt   <= '0;
         lfsr       <= LFSR_SEED;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         vram_ce_o  <= 1'b0;
         vram_ad_o  <= '0;
         vram_din_o <= '0;
      end else begin
         done_o    <= 1'b0;
         vram_ce_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i && !abort_i) begin
                  mode_r     <= mode_i;
                  loop_r     <= loop_i;
                  base_r     <= base_i;
                  len_r      <= len_i;
                  div_r      <= div_i;
                  const_r    <= const_i;
                  offset     <= '0;
                  lfsr       <= LFSR_SEED;
                  busy_o     <= 1'b1;
                  vram_ce_o  <= 1'b1;
                  vram_ad_o  <= base_i;
                  vram_din_o <= fill_data(mode_i, const_i, '0, LFSR_SEED);
                  state      <= WRITE;
               end
            end

            WRITE: begin
               if (abort_i) begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end else begin
                  lfsr   <= lfsr_nx;
                  offset <= offset_nx;
                  done_o <= last_word;
                  if (last_word && !loop_r) begin
                     busy_o <= 1'b0;
                     state  <= IDLE;
                  end else if (div_r == '0) begin
                     vram_ce_o  <= 1'b1;
                     vram_ad_o  <= base_r + offset_nx;
                     vram_din_o <= fill_data(mode_r, const_r, offset_nx, lfsr_nx);
                     state      <= WRITE;
                  end else begin
                     wait_cnt <= div_r - DIV_W'(1);
                     state    <= WAIT;
                  end
               end
            end

            WAIT: begin
               if (abort_i) begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end else if (wait_cnt == '0) begin
                  vram_ce_o  <= 1'b1;
                  vram_ad_o  <= base_r + offset;
                  vram_din_o <= fill_data(mode_r, const_r, offset, lfsr);
                  state      <= WRITE;
               end else begin
                  wait_cnt <= wait_cnt - DIV_W'(1);
               end
            end

            default: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/vram_filler.md
VRAM_FILLER -- requirements
Module: vram_filler

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, VRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, VRAM word width.
REQ-003 SHALL have parameter DIV_W, default 17, rate-divider width.
REQ-004 SHALL have parameter LFSR_TAPS, default 16'hB400, feedback mask (bits 15,13,12,10), DATA_W bits.
REQ-005 SHALL have parameter LFSR_SEED, default 16'h0001, nonzero LFSR load value, DATA_W bits.
REQ-006 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start_i  in  1  start request, sampled in IDLE only.
REQ-009 SHALL have port abort_i  in  1  stop the current fill.
REQ-010 SHALL have port mode_i  in  2  0=CONST, 1=INCR, 2=LFSR, 3=CHECKER.
REQ-011 SHALL have port loop_i  in  1  repeat the region indefinitely.
REQ-012 SHALL have port base_i  in  ADDR_W  first word address.
REQ-013 SHALL have port len_i  in  ADDR_W  word count minus one.
REQ-014 SHALL have port div_i  in  DIV_W  write spacing minus one, in clocks.
REQ-015 SHALL have port const_i  in  DATA_W  fill constant.
REQ-016 SHALL have port busy_o  out  1  fill in progress.
REQ-017 SHALL have port done_o  out  1  one-cycle pulse at end of each pass.
REQ-018 SHALL have port vram_ce_o  out  1  one-cycle write strobe.
REQ-019 SHALL have port vram_ad_o  out  ADDR_W  write address.
REQ-020 SHALL have port vram_din_o  out  DATA_W  write data.

Function
REQ-021 SHALL implement FSM states IDLE, WRITE, WAIT; all outputs registered.
REQ-022 IDLE: start_i=1 at edge T SHALL latch mode/loop/base/len/div/const, clear offset, go to WRITE; later input changes ignored until the next IDLE.
REQ-023 WRITE SHALL last one cycle with vram_ce_o=1, vram_ad_o=(base+offset) mod 2^ADDR_W, vram_din_o per mode; first strobe occurs in cycle T+1.
REQ-024 From WRITE: offset==len and loop=0 -> IDLE; offset==len and loop=1 -> offset=0, continue; else offset+1; next state WRITE if div==0, else WAIT.
REQ-025 WAIT SHALL hold vram_ce_o=0 for exactly div cycles, then enter WRITE; strobes spaced div+1 clocks.
REQ-026 Data: CONST=const; INCR=offset zero-extended/truncated to DATA_W; LFSR=current LFSR value; CHECKER=const if offset[0]==0, else ~const.
REQ-027 LFSR SHALL load LFSR_SEED on each accepted start and advance once per WRITE only: next={lfsr[DATA_W-2:0], ^(lfsr & LFSR_TAPS)}; it continues across loop passes.
REQ-028 If the LFSR register ever holds zero, it SHALL reload LFSR_SEED on the next advance.
REQ-029 done_o SHALL pulse 1 cycle in the cycle after the last WRITE of each pass, including looped passes.
REQ-030 busy_o SHALL be 1 from cycle T+1 through the last WRITE and 0 in the done_o cycle when not looping.
REQ-031 Start SHALL be accepted in the done_o cycle (state IDLE).
REQ-032 abort_i=1 in WRITE/WAIT SHALL go to IDLE at that edge: busy_o=0 and vram_ce_o=0 next cycle, no done_o.
REQ-033 abort_i and start_i both high in IDLE SHALL leave the block in IDLE.
REQ-034 start_i while busy SHALL be ignored.
REQ-035 vram_ad_o and vram_din_o SHALL hold their last values while vram_ce_o=0.

Reset
REQ-036 rst_n_i=0 SHALL immediately force state IDLE, busy_o=0, done_o=0, vram_ce_o=0, vram_ad_o=0, vram_din_o=0, offset=0, divider=0, LFSR=LFSR_SEED.
REQ-037 Reset asserted mid-fill SHALL abandon the fill with no done_o; after release, the block waits for a new start_i.

Verification
REQ-038 CONST, base=5, len=3, div=0, const=16'hA5A5, start at T -> strobes T+1..T+4 at 5,6,7,8 with data A5A5; done_o at T+5; busy_o high T+1..T+4.
REQ-039 INCR, base=1020, len=7, div=2 (ADDR_W=10) -> addresses 1020..1023,0..3, data 0..7, strobes 3 clocks apart, one done_o.
REQ-040 LFSR, len=3, div=0 -> data 0001,0002,0004,0008; a second start repeats the same sequence.
REQ-041 CHECKER, loop=1, len=1, const=16'h00FF -> data 00FF,FF00 repeating, done_o every 2 strobes; abort_i -> no further strobes and no done_o.
REQ-042 start_i pulsed mid-fill and start_i+abort_i together in IDLE -> ignored; rst_n_i low during WAIT -> all outputs 0 immediately.
